// File: rtl/clock_set_controller.sv
// clock_set_controller
//   Front-panel control stage of the alarm clock. Synchronises and debounces
//   the four raw push-buttons, runs the set-mode state machine, and generates
//   the single-cycle adjust pulses (with auto-repeat) and the gated seconds
//   enable for the time and alarm counters downstream.
//
// Ports
//   clk, reset                 system clock, asynchronous active-high reset
//   sample_tick                one-clk debounce sample strobe
//   sec_tick                   one-clk 1 Hz strobe
//   btn_mode/up/down/sel       raw asynchronous buttons, active-high
//   mode[2:0]                  0 RUN, 1 SET_MIN, 2 SET_HR, 3 ALM_MIN, 4 ALM_HR
//   sec_en                     seconds-counter enable (registered)
//   tmin_*/thr_*/amin_*/ahr_*  registered one-clk adjust pulses
//   alarm_arm                  alarm armed flag
module clock_set_controller #(
    parameter int DB_SAMPLES = 4,
    parameter int RPT_DELAY  = 100,
    parameter int RPT_PERIOD = 20,
    parameter int TIMEOUT    = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_tick,
    input  logic       sec_tick,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_sel,
    output logic [2:0] mode,
    output logic       sec_en,
    output logic       tmin_up,
    output logic       tmin_dn,
    output logic       thr_up,
    output logic       thr_dn,
    output logic       amin_up,
    output logic       amin_dn,
    output logic       ahr_up,
    output logic       ahr_dn,
    output logic       alarm_arm
);
    localparam logic [2:0] RUN     = 3'd0;
    localparam logic [2:0] SET_MIN = 3'd1;
    localparam logic [2:0] SET_HR  = 3'd2;
    localparam logic [2:0] ALM_MIN = 3'd3;
    localparam logic [2:0] ALM_HR  = 3'd4;

    localparam int NUM_BTN = 4;  // 0 mode, 1 sel, 2 up, 3 down

    localparam logic [3:0] DB_LAST = 4'(DB_SAMPLES - 1);
    localparam logic [7:0] RPT_D   = 8'(RPT_DELAY);
    localparam logic [7:0] RPT_P   = 8'(RPT_PERIOD);
    localparam logic [5:0] TO_CNT  = 6'(TIMEOUT);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] lvl;
    logic [NUM_BTN-1:0] lvl_d;
    logic [NUM_BTN-1:0] rpt;
    logic [NUM_BTN-1:0] hold;
    logic [NUM_BTN-1:0] ev_nxt;
    logic [NUM_BTN-1:0] ev;
    logic               conflict;

    logic [2:0] mode_nxt;
    logic       arm_nxt;
    logic [7:0] adj;
    logic [7:0] adj_nxt;
    logic [5:0] idle;
    logic [5:0] idle_nxt;
    logic [1:0] ud;

    assign raw      = {btn_down, btn_up, btn_sel, btn_mode};
    assign conflict = lvl[3] & lvl[2];
    // mode/sel never auto-repeat: their repeat counters are held at 0 for good.
    // up/down counters are held while both are down together.
    assign hold     = {conflict, conflict, 2'b11};

    // Per-button synchroniser, debouncer and repeat counter.
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        logic [1:0] sync;
        logic [3:0] db_cnt;
        logic       level;
        logic [7:0] rpt_cnt;
        logic [7:0] rpt_inc;
        logic [7:0] rpt_tgt;
        logic       rpt_run;
        logic       rpt_hit;

        assign rpt_inc = rpt_cnt + 8'd1;
        // First repeat waits RPT_DELAY ticks, later ones RPT_PERIOD ticks.
        assign rpt_tgt = rpt_run ? RPT_P : RPT_D;
        assign rpt_hit = sample_tick & level & ~hold[i] & (rpt_inc == rpt_tgt);
        assign lvl[i]  = level;
        assign rpt[i]  = rpt_hit;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync   <= '0;
                db_cnt <= '0;
                level  <= 1'b0;
            end else begin
                sync <= {sync[0], raw[i]};
                // sync[1] is the registered value, so a tick that coincides
                // with a synchroniser change sees the old level.
                if (sample_tick) begin
                    if (sync[1] == level) begin
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        level  <= sync[1];
                        db_cnt <= '0;
                    end else begin
                        db_cnt <= db_cnt + 4'd1;
                    end
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rpt_cnt <= '0;
                rpt_run <= 1'b0;
            end else if (!level || hold[i]) begin
                rpt_cnt <= '0;
                rpt_run <= 1'b0;
            end else if (sample_tick) begin
                if (rpt_hit) begin
                    rpt_cnt <= '0;
                    rpt_run <= 1'b1;
                end else begin
                    rpt_cnt <= rpt_inc;
                end
            end
        end
    end

    // Press = debounced rising edge; up/down presses are dropped on conflict.
    assign ev_nxt = ((lvl & ~lvl_d) | rpt) & ~{conflict, conflict, 2'b00};

    always_comb begin
        mode_nxt = mode;
        arm_nxt  = alarm_arm;
        adj_nxt  = '0;
        idle_nxt = idle;
        ud       = ev[2] ? 2'b10 : 2'b01;

        // Priority mode > sel > up/down; lower-priority events are discarded.
        if (ev[0]) begin
            mode_nxt = (mode >= ALM_HR) ? RUN : mode + 3'd1;
        end else if (ev[1]) begin
            if (mode == RUN) arm_nxt  = ~alarm_arm;
            else             mode_nxt = RUN;
        end else if (ev[2] | ev[3]) begin
            case (mode)
                SET_MIN: adj_nxt[7:6] = ud;
                SET_HR:  adj_nxt[5:4] = ud;
                ALM_MIN: adj_nxt[3:2] = ud;
                ALM_HR:  adj_nxt[1:0] = ud;
                default: ;
            endcase
        end

        // Idle timeout: any event or state change restarts it; frozen in RUN.
        if (mode == RUN || ev != '0 || mode_nxt != mode) begin
            idle_nxt = '0;
        end else if (sec_tick) begin
            if (idle + 6'd1 == TO_CNT) begin
                mode_nxt = RUN;
                idle_nxt = '0;
            end else begin
                idle_nxt = idle + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl_d     <= '0;
            ev        <= '0;
            mode      <= RUN;
            alarm_arm <= 1'b0;
            adj       <= '0;
            idle      <= '0;
            sec_en    <= 1'b0;
        end else begin
            lvl_d     <= lvl;
            ev        <= ev_nxt;
            mode      <= mode_nxt;
            alarm_arm <= arm_nxt;
            adj       <= adj_nxt;
            idle      <= idle_nxt;
            // Time is frozen while it is being set.
            sec_en    <= sec_tick & (mode != SET_MIN) & (mode != SET_HR);
        end
    end

    assign {tmin_up, tmin_dn, thr_up, thr_dn, amin_up, amin_dn, ahr_up, ahr_dn} = adj;

endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller
//   Table of button presses with expected mode/arm, a pulse scoreboard fed
//   when stimulus is driven, and hand sequences for debounce latency/bounce,
//   auto-repeat, up/down conflict, timeout, sec_en and asynchronous reset.
module tb_clock_set_controller;
    localparam int DB = 4;

    localparam logic [1:0] B_MODE = 2'd0;
    localparam logic [1:0] B_SEL  = 2'd1;
    localparam logic [1:0] B_UP   = 2'd2;
    localparam logic [1:0] B_DN   = 2'd3;

    localparam logic [7:0] A_NONE    = 8'h00;
    localparam logic [7:0] A_TMIN_UP = 8'h80;
    localparam logic [7:0] A_TMIN_DN = 8'h40;
    localparam logic [7:0] A_THR_UP  = 8'h20;
    localparam logic [7:0] A_THR_DN  = 8'h10;
    localparam logic [7:0] A_AMIN_UP = 8'h08;
    localparam logic [7:0] A_AMIN_DN = 8'h04;
    localparam logic [7:0] A_AHR_UP  = 8'h02;

    typedef struct packed {
        logic [1:0] btn;
        logic [2:0] mode;
        logic       arm;
        logic [7:0] adj;
    } vec_t;

    logic       clk         = 1'b0;
    logic       reset       = 1'b1;
    logic       sample_tick = 1'b0;
    logic       sec_tick    = 1'b0;
    logic [3:0] raw         = '0;

    logic [2:0] mode;
    logic       sec_en, alarm_arm;
    logic       tmin_up, tmin_dn, thr_up, thr_dn, amin_up, amin_dn, ahr_up, ahr_dn;
    logic [7:0] adj;

    logic [7:0] exp_q[$];
    logic [7:0] exp_adj;
    vec_t       tbl [16];
    int         seq_mode [5] = '{1, 2, 3, 4, 0};
    int         seq_en   [5] = '{0, 0, 1, 1, 1};

    int n_chk = 0, n_fail = 0, n_pulse = 0, cyc = 0, last_pulse_cyc = 0;
    int t0, pc;

    clock_set_controller #(
        .DB_SAMPLES(DB), .RPT_DELAY(5), .RPT_PERIOD(2), .TIMEOUT(3)
    ) dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .sec_tick(sec_tick),
        .btn_mode(raw[0]), .btn_up(raw[2]), .btn_down(raw[3]), .btn_sel(raw[1]),
        .mode(mode), .sec_en(sec_en),
        .tmin_up(tmin_up), .tmin_dn(tmin_dn), .thr_up(thr_up), .thr_dn(thr_dn),
        .amin_up(amin_up), .amin_dn(amin_dn), .ahr_up(ahr_up), .ahr_dn(ahr_dn),
        .alarm_arm(alarm_arm)
    );

    assign adj = {tmin_up, tmin_dn, thr_up, thr_dn, amin_up, amin_dn, ahr_up, ahr_dn};

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // sample_tick: one clk high every 10 clks
    initial forever begin
        repeat (9) @(posedge clk);
        #1 sample_tick = 1'b1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
    end

    // Scoreboard: every adjust pulse must match the next expected one.
    initial forever begin
        @(negedge clk);
        if (adj != 8'h00) begin
            n_pulse++;
            last_pulse_cyc = cyc;
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard: unexpected adjust pulse %b at cycle %0d", adj, cyc);
            end else begin
                exp_adj = exp_q.pop_front();
                if (adj !== exp_adj) begin
                    n_fail++;
                    $display("FAIL scoreboard: adjust got %b, expected %b at cycle %0d", adj, exp_adj, cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Returns just after the posedge at which sample_tick is sampled high.
    task automatic wait_tick();
        do @(posedge clk); while (sample_tick !== 1'b1);
    endtask

    // Clean press: raw high for exactly DB ticks, so the debounced level is
    // high for DB ticks (fewer than RPT_DELAY) -> one press, no repeat.
    task automatic press(input int b);
        wait_tick();
        #1 raw[b] = 1'b1;
        repeat (DB) wait_tick();
        #1 raw[b] = 1'b0;
        repeat (DB + 2) wait_tick();
    endtask

    task automatic sec_pulse();
        @(posedge clk);
        #1 sec_tick = 1'b1;
        @(posedge clk);
        #1 sec_tick = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        tbl[0]  = '{B_SEL,  3'd0, 1'b1, A_NONE};
        tbl[1]  = '{B_UP,   3'd0, 1'b1, A_NONE};
        tbl[2]  = '{B_MODE, 3'd1, 1'b1, A_NONE};
        tbl[3]  = '{B_UP,   3'd1, 1'b1, A_TMIN_UP};
        tbl[4]  = '{B_DN,   3'd1, 1'b1, A_TMIN_DN};
        tbl[5]  = '{B_MODE, 3'd2, 1'b1, A_NONE};
        tbl[6]  = '{B_UP,   3'd2, 1'b1, A_THR_UP};
        tbl[7]  = '{B_DN,   3'd2, 1'b1, A_THR_DN};
        tbl[8]  = '{B_MODE, 3'd3, 1'b1, A_NONE};
        tbl[9]  = '{B_DN,   3'd3, 1'b1, A_AMIN_DN};
        tbl[10] = '{B_MODE, 3'd4, 1'b1, A_NONE};
        tbl[11] = '{B_UP,   3'd4, 1'b1, A_AHR_UP};
        tbl[12] = '{B_MODE, 3'd0, 1'b1, A_NONE};
        tbl[13] = '{B_SEL,  3'd0, 1'b0, A_NONE};
        tbl[14] = '{B_MODE, 3'd1, 1'b0, A_NONE};
        tbl[15] = '{B_SEL,  3'd0, 1'b0, A_NONE};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset mode", mode, 0);
        check("reset alarm_arm", alarm_arm, 0);
        check("reset adjust", adj, 0);
        check("reset sec_en", sec_en, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Table-driven presses
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].adj != A_NONE) exp_q.push_back(tbl[i].adj);
            press(tbl[i].btn);
            @(negedge clk);
            check($sformatf("tbl%0d mode", i), mode, tbl[i].mode);
            check($sformatf("tbl%0d alarm_arm", i), alarm_arm, tbl[i].arm);
        end

        // Mode cycle with sec_en gating
        for (int i = 0; i < 5; i++) begin
            press(B_MODE);
            @(negedge clk);
            check($sformatf("cycle%0d mode", i), mode, seq_mode[i]);
            sec_pulse();
            @(negedge clk);
            check($sformatf("cycle%0d sec_en idle", i), sec_en, 0);
            @(posedge clk);
            #1 sec_tick = 1'b1;
            @(posedge clk);
            #1 sec_tick = 1'b0;
            @(negedge clk);
            check($sformatf("cycle%0d sec_en", i), sec_en, seq_en[i]);
            @(negedge clk);
            check($sformatf("cycle%0d sec_en after", i), sec_en, 0);
        end

        // Press latency and bounce rejection in SET_MIN
        press(B_MODE);
        @(negedge clk);
        check("lat mode", mode, 1);
        pc = n_pulse;
        exp_q.push_back(A_TMIN_UP);
        wait_tick();
        #1 raw[B_UP] = 1'b1;
        t0 = cyc;
        repeat (DB) wait_tick();
        #1 raw[B_UP] = 1'b0;
        repeat (DB + 2) wait_tick();
        check("lat pulse count", n_pulse - pc, 1);
        check_range("lat press latency", last_pulse_cyc - t0, 42, 52);
        pc = n_pulse;
        wait_tick();
        #1 raw[B_UP] = 1'b1;
        repeat (DB - 1) wait_tick();
        #1 raw[B_UP] = 1'b0;
        repeat (DB + 2) wait_tick();
        check("bounce no pulse", n_pulse - pc, 0);

        // Auto-repeat in SET_HR: debounced high for 12 ticks -> 1 + 4 pulses
        press(B_MODE);
        @(negedge clk);
        check("rpt mode", mode, 2);
        pc = n_pulse;
        repeat (5) exp_q.push_back(A_THR_DN);
        wait_tick();
        #1 raw[B_DN] = 1'b1;
        repeat (DB) wait_tick();
        repeat (8) wait_tick();
        #1 raw[B_DN] = 1'b0;
        repeat (8) wait_tick();
        check("rpt thr_dn count", n_pulse - pc, 5);
        repeat (10) wait_tick();
        check("rpt none after release", n_pulse - pc, 5);

        // Up/down conflict in SET_MIN
        press(B_SEL);
        press(B_MODE);
        @(negedge clk);
        check("conf mode", mode, 1);
        pc = n_pulse;
        wait_tick();
        #1 raw[B_UP] = 1'b1;
        raw[B_DN] = 1'b1;
        repeat (14) wait_tick();
        check("conf both held", n_pulse - pc, 0);
        #1 raw[B_DN] = 1'b0;
        repeat (8) wait_tick();
        check("conf no re-press", n_pulse - pc, 0);
        repeat (3) exp_q.push_back(A_TMIN_UP);
        wait_tick();
        #1 raw[B_UP] = 1'b0;
        repeat (8) wait_tick();
        check("conf repeats resume", n_pulse - pc, 3);

        // Timeout from ALM_MIN
        press(B_SEL);
        repeat (3) press(B_MODE);
        @(negedge clk);
        check("to mode alm_min", mode, 3);
        repeat (2) sec_pulse();
        @(negedge clk);
        check("to after 2 ticks", mode, 3);
        sec_pulse();
        @(negedge clk);
        check("to after 3 ticks", mode, 0);
        repeat (3) press(B_MODE);
        repeat (2) sec_pulse();
        exp_q.push_back(A_AMIN_UP);
        press(B_UP);
        repeat (2) sec_pulse();
        @(negedge clk);
        check("to restart tick 4", mode, 3);
        sec_pulse();
        @(negedge clk);
        check("to restart tick 5", mode, 0);

        // Asynchronous reset mid-debounce, then fresh press of a held button
        press(B_SEL);
        @(negedge clk);
        check("rst arm set", alarm_arm, 1);
        press(B_MODE);
        @(negedge clk);
        check("rst pre mode", mode, 1);
        wait_tick();
        #1 raw[B_MODE] = 1'b1;
        repeat (2) wait_tick();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst async mode", mode, 0);
        check("rst async arm", alarm_arm, 0);
        check("rst async adjust", adj, 0);
        check("rst async sec_en", sec_en, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (DB + 3) wait_tick();
        @(negedge clk);
        check("rst fresh press", mode, 1);
        #1 raw[B_MODE] = 1'b0;
        repeat (DB + 2) wait_tick();

        check("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
